// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared response codes and FSM state types for the AXI4-Lite register slave
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi4lite_regfile.sv
// rtl/axi4lite_regfile.sv - register bank with byte-strobed write port, async read and write strobes
module axi4lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // wr_pulse fires whenever a write is committed, even with an all-zero strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_en ? (NUM_REGS'(1) << wr_idx) : '0;
            if (wr_en) begin
                for (int k = 0; k < DATA_WIDTH/8; k++) begin
                    if (wr_strb[k]) begin
                        mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// rtl/axi4lite_reg_slave.sv - AXI4-Lite slave exposing a bank of 32-bit control/status registers
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH/8;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    // Word offsets keep their full width so the range test catches addresses below BASE_ADDR via wrap
    logic [ADDR_WIDTH-1:0] aw_word, ar_word;
    logic                  aw_ok, ar_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    assign aw_word = (aw_addr_q - BASE_ADDR) >> 2;
    assign ar_word = (araddr - BASE_ADDR) >> 2;
    assign aw_ok   = aw_word < ADDR_WIDTH'(NUM_REGS);
    assign ar_ok   = ar_word < ADDR_WIDTH'(NUM_REGS);

    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (wr_state_q == W_COLLECT) && aw_held && w_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_COLLECT;
            rd_state_q <= R_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_COLLECT: if (aw_held && w_held) wr_state_d = W_RESP;
            W_RESP:    if (bready)            wr_state_d = W_COLLECT;
            default:   wr_state_d = W_COLLECT;
        endcase
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (arvalid) rd_state_d = R_DATA;
            R_DATA:  if (rready)  rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        awready = (wr_state_q == W_COLLECT) && !aw_held;
        wready  = (wr_state_q == W_COLLECT) && !w_held;
        arready = (rd_state_q == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // rdata is sampled from the pre-edge register contents, so a same-edge write is not visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= ar_ok ? rd_data : '0;
            rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    axi4lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (commit && aw_ok),
        .wr_idx   (aw_word[IDX_W-1:0]),
        .wr_data  (w_data_q),
        .wr_strb  (w_strb_q),
        .rd_idx   (ar_word[IDX_W-1:0]),
        .rd_data  (rd_data),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

endmodule
